// File: rtl/control_s_axi_mc_pkg.sv
// Shared types and constants for the multi-channel AXI4-Lite control slave.
package control_s_axi_mc_pkg;

    typedef enum logic [1:0] {
        WRIDLE  = 2'd0,
        WRDATA  = 2'd1,
        WRRESP  = 2'd2,
        WRRESET = 2'd3
    } wstate_t;

    typedef enum logic [1:0] {
        RDIDLE  = 2'd0,
        RDDATA  = 2'd1,
        RDRESET = 2'd2
    } rstate_t;

    // Result of decoding a bus address against the register map.
    typedef enum logic [2:0] {
        KIND_NONE = 3'd0,
        KIND_GIE  = 3'd1,
        KIND_IER  = 3'd2,
        KIND_ISR  = 3'd3,
        KIND_INFO = 3'd4,
        KIND_CTRL = 3'd5,
        KIND_ARG  = 3'd6
    } reg_kind_t;

    localparam logic [7:0] ADDR_GIE  = 8'h00;
    localparam logic [7:0] ADDR_IER  = 8'h04;
    localparam logic [7:0] ADDR_ISR  = 8'h08;
    localparam logic [7:0] ADDR_INFO = 8'h0C;
    localparam logic [7:0] CH_BASE   = 8'h10;

    localparam int CTRL_START = 0;
    localparam int CTRL_DONE  = 1;
    localparam int CTRL_IDLE  = 2;
    localparam int CTRL_READY = 3;
    localparam int CTRL_CONT  = 4;
    localparam int CTRL_AUTO  = 7;
    localparam int CTRL_GIE   = 9;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [7:0] INFO_VERSION = 8'h02;

    // Expand a 4-bit byte strobe into a 32-bit bit mask.
    function automatic logic [31:0] strb_mask(input logic [3:0] strb);
        return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    endfunction

endpackage

// File: rtl/control_s_axi_mc_ch.sv
// One accelerator channel: handshake state, CTRL read image and argument registers.
module control_s_axi_mc_ch
    import control_s_axi_mc_pkg::*;
#(
    parameter int NUM_ARGS   = 3,
    parameter int CHAIN_MODE = 0
) (
    input  logic                     ACLK,
    input  logic                     ARESETN,
    input  logic                     ACLK_EN,
    input  logic                     ctrl_wr,
    input  logic [NUM_ARGS-1:0]      arg_wr,
    input  logic [31:0]              wdata,
    input  logic [3:0]               wstrb,
    input  logic                     ctrl_rd,
    input  logic                     gie,
    input  logic                     ap_done,
    input  logic                     ap_ready,
    input  logic                     ap_idle,
    output logic [31:0]              ctrl_rdata,
    output logic                     ap_start,
    output logic                     ap_continue,
    output logic [NUM_ARGS*32-1:0]   args
);

    logic start_r, done_r, ready_r, idle_r, auto_r, cont_r;
    logic start_s, done_s, ready_s, auto_s, cont_s;
    logic byte0_wr_s, idle_rise_s, done_set_s, ready_set_s;
    logic [NUM_ARGS*32-1:0] args_r, args_s;

    // Next-state for the handshake bits; a latch set beats a same-cycle clear-on-read.
    always_comb begin
        byte0_wr_s  = ctrl_wr && wstrb[0];
        start_s     = (byte0_wr_s && wdata[CTRL_START]) ? 1'b1 : (ap_ready ? auto_r : start_r);
        auto_s      = byte0_wr_s ? wdata[CTRL_AUTO] : auto_r;
        idle_rise_s = auto_r && ap_idle && !idle_r;
        done_set_s  = (ap_done && !auto_r) || idle_rise_s;
        ready_set_s = ap_ready && !auto_r;
        done_s      = done_set_s  ? 1'b1 : (ctrl_rd ? 1'b0 : done_r);
        ready_s     = ready_set_s ? 1'b1 : (ctrl_rd ? 1'b0 : ready_r);
        cont_s      = (CHAIN_MODE != 0) && byte0_wr_s && wdata[CTRL_CONT];
    end

    // Byte-strobed argument register update.
    always_comb begin
        args_s = args_r;
        for (int a = 0; a < NUM_ARGS; a++) begin
            for (int b = 0; b < 4; b++) begin
                args_s[a*32+b*8 +: 8] = (arg_wr[a] && wstrb[b]) ? wdata[b*8 +: 8]
                                                                 : args_r[a*32+b*8 +: 8];
            end
        end
    end

    // Channel state registers.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            start_r <= 1'b0;
            done_r  <= 1'b0;
            ready_r <= 1'b0;
            idle_r  <= 1'b0;
            auto_r  <= 1'b0;
            cont_r  <= 1'b0;
            args_r  <= '0;
        end else if (ACLK_EN) begin
            start_r <= start_s;
            done_r  <= done_s;
            ready_r <= ready_s;
            idle_r  <= ap_idle;
            auto_r  <= auto_s;
            cont_r  <= cont_s;
            args_r  <= args_s;
        end
    end

    // CTRL read image; ap_continue is write-only and reads back 0.
    always_comb begin
        ctrl_rdata             = 32'd0;
        ctrl_rdata[CTRL_START] = start_r;
        ctrl_rdata[CTRL_DONE]  = done_r;
        ctrl_rdata[CTRL_IDLE]  = idle_r;
        ctrl_rdata[CTRL_READY] = ready_r;
        ctrl_rdata[CTRL_AUTO]  = auto_r;
        ctrl_rdata[CTRL_GIE]   = gie;
    end

    assign ap_start    = start_r;
    assign ap_continue = cont_r;
    assign args        = args_r;

endmodule

// File: rtl/control_s_axi_mc.sv
// AXI4-Lite control slave for NUM_CH accelerator channels with a shared interrupt.
module control_s_axi_mc
    import control_s_axi_mc_pkg::*;
#(
    parameter int C_S_AXI_ADDR_WIDTH = 8,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int NUM_CH             = 4,
    parameter int NUM_ARGS           = 3,
    parameter int CHAIN_MODE         = 0
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic                            ACLK_EN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   AWADDR,
    input  logic                            AWVALID,
    output logic                            AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] WSTRB,
    input  logic                            WVALID,
    output logic                            WREADY,
    output logic [1:0]                      BRESP,
    output logic                            BVALID,
    input  logic                            BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   ARADDR,
    input  logic                            ARVALID,
    output logic                            ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]                      RRESP,
    output logic                            RVALID,
    input  logic                            RREADY,
    output logic                            interrupt,
    output logic [NUM_CH-1:0]               ap_start,
    output logic [NUM_CH-1:0]               ap_continue,
    input  logic [NUM_CH-1:0]               ap_done,
    input  logic [NUM_CH-1:0]               ap_ready,
    input  logic [NUM_CH-1:0]               ap_idle,
    output logic [NUM_CH*NUM_ARGS*32-1:0]   ch_args
);

    localparam int          ARG_BITS  = $clog2(NUM_ARGS + 1);
    localparam int          CH_STRIDE = 4 << ARG_BITS;
    localparam logic [31:0] SLOT_MASK = 32'((1 << ARG_BITS) - 1);

    if (C_S_AXI_DATA_WIDTH != 32) begin : g_bad_data_width
        $error("control_s_axi_mc: C_S_AXI_DATA_WIDTH must be 32");
    end
    if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
        $error("control_s_axi_mc: NUM_CH must be 1..8");
    end
    if (C_S_AXI_ADDR_WIDTH < $clog2(16 + NUM_CH * CH_STRIDE)) begin : g_bad_addr_width
        $error("control_s_axi_mc: C_S_AXI_ADDR_WIDTH too small for the channel map");
    end

    wstate_t wstate_r, wstate_s;
    rstate_t rstate_r, rstate_s;
    logic [C_S_AXI_ADDR_WIDTH-1:0] waddr_r;
    logic [1:0]  bresp_r, rresp_r, rresp_s;
    logic [31:0] rdata_r, rdata_s, wmask_s;
    logic        gie_r, gie_s, interrupt_r;
    logic [2*NUM_CH-1:0] ier_r, ier_s, isr_r, isr_s;
    logic        aw_hs_s, w_hs_s, ar_hs_s;
    reg_kind_t   wkind_s, rkind_s;
    logic [31:0] wch_s, warg_s, rch_s, rarg_s;
    logic [NUM_CH-1:0]          ctrl_wr_s, ctrl_rd_s;
    logic [NUM_CH*NUM_ARGS-1:0] arg_wr_s;
    logic [31:0]                ctrl_rdata_s [NUM_CH];
    logic [NUM_CH*NUM_ARGS*32-1:0] ch_args_s;

    // Map a byte address to a register kind plus channel/argument index.
    function automatic void decode_addr(
        input  logic [C_S_AXI_ADDR_WIDTH-1:0] addr,
        output reg_kind_t                     kind,
        output logic [31:0]                   ch_idx,
        output logic [31:0]                   arg_idx
    );
        logic [31:0] word_v, off_v, slot_v;
        word_v  = 32'(addr) & 32'hFFFF_FFFC;
        off_v   = word_v - 32'(CH_BASE);
        ch_idx  = off_v >> (ARG_BITS + 2);
        slot_v  = (off_v >> 2) & SLOT_MASK;
        arg_idx = slot_v - 32'd1;
        if      (word_v == 32'(ADDR_GIE))  kind = KIND_GIE;
        else if (word_v == 32'(ADDR_IER))  kind = KIND_IER;
        else if (word_v == 32'(ADDR_ISR))  kind = KIND_ISR;
        else if (word_v == 32'(ADDR_INFO)) kind = KIND_INFO;
        else if (ch_idx >= 32'(NUM_CH))    kind = KIND_NONE;
        else if (slot_v == 32'd0)          kind = KIND_CTRL;
        else if (slot_v <= 32'(NUM_ARGS))  kind = KIND_ARG;
        else                               kind = KIND_NONE;
    endfunction

    assign aw_hs_s = AWVALID && (wstate_r == WRIDLE);
    assign w_hs_s  = WVALID  && (wstate_r == WRDATA);
    assign ar_hs_s = ARVALID && (rstate_r == RDIDLE);
    assign wmask_s = strb_mask(WSTRB);

    // Decode the latched write address and the live read address.
    always_comb begin
        decode_addr(waddr_r, wkind_s, wch_s, warg_s);
        decode_addr(ARADDR, rkind_s, rch_s, rarg_s);
    end

    // Write FSM next state.
    always_comb begin
        wstate_s = wstate_r;
        case (wstate_r)
            WRRESET: wstate_s = WRIDLE;
            WRIDLE:  wstate_s = AWVALID ? WRDATA : WRIDLE;
            WRDATA:  wstate_s = WVALID  ? WRRESP : WRDATA;
            WRRESP:  wstate_s = BREADY  ? WRIDLE : WRRESP;
            default: wstate_s = WRIDLE;
        endcase
    end

    // Read FSM next state.
    always_comb begin
        rstate_s = rstate_r;
        case (rstate_r)
            RDRESET: rstate_s = RDIDLE;
            RDIDLE:  rstate_s = ARVALID ? RDDATA : RDIDLE;
            RDDATA:  rstate_s = RREADY  ? RDIDLE : RDDATA;
            default: rstate_s = RDIDLE;
        endcase
    end

    // FSM state registers.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            wstate_r <= WRRESET;
            rstate_r <= RDRESET;
        end else if (ACLK_EN) begin
            wstate_r <= wstate_s;
            rstate_r <= rstate_s;
        end
    end

    // Per-channel write and clear-on-read strobes.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            ctrl_wr_s[c] = w_hs_s  && (wkind_s == KIND_CTRL) && (wch_s == 32'(c));
            ctrl_rd_s[c] = ar_hs_s && (rkind_s == KIND_CTRL) && (rch_s == 32'(c));
            for (int a = 0; a < NUM_ARGS; a++) begin
                arg_wr_s[c*NUM_ARGS+a] = w_hs_s && (wkind_s == KIND_ARG) &&
                                         (wch_s == 32'(c)) && (warg_s == 32'(a));
            end
        end
    end

    // Read data mux; unmapped addresses return zero with SLVERR.
    always_comb begin
        rdata_s = 32'd0;
        rresp_s = RESP_OKAY;
        case (rkind_s)
            KIND_GIE:  rdata_s = {31'd0, gie_r};
            KIND_IER:  rdata_s = 32'(ier_r);
            KIND_ISR:  rdata_s = 32'(isr_r);
            KIND_INFO: rdata_s = {INFO_VERSION, 8'(NUM_ARGS), 8'(NUM_CH), 8'(CHAIN_MODE)};
            KIND_CTRL: begin
                for (int c = 0; c < NUM_CH; c++) begin
                    rdata_s = rdata_s | (ctrl_rdata_s[c] & {32{rch_s == 32'(c)}});
                end
            end
            KIND_ARG: begin
                for (int c = 0; c < NUM_CH; c++) begin
                    for (int a = 0; a < NUM_ARGS; a++) begin
                        rdata_s = rdata_s | (ch_args_s[(c*NUM_ARGS+a)*32 +: 32] &
                                  {32{(rch_s == 32'(c)) && (rarg_s == 32'(a))}});
                    end
                end
            end
            default: rresp_s = RESP_SLVERR;
        endcase
    end

    // Global register next state; a kernel event beats a same-cycle ISR toggle.
    always_comb begin
        gie_s = (w_hs_s && (wkind_s == KIND_GIE) && wmask_s[0]) ? WDATA[0] : gie_r;
        for (int i = 0; i < 2*NUM_CH; i++) begin
            ier_s[i] = (w_hs_s && (wkind_s == KIND_IER) && wmask_s[i]) ? WDATA[i] : ier_r[i];
            isr_s[i] = (ier_r[i] && (((i % 2) == 0) ? ap_done[i/2] : ap_ready[i/2])) ? 1'b1 :
                       (isr_r[i] ^ (w_hs_s && (wkind_s == KIND_ISR) && wmask_s[i] && WDATA[i]));
        end
    end

    // Bus-side datapath registers and the aggregated interrupt.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            waddr_r     <= '0;
            bresp_r     <= RESP_OKAY;
            rdata_r     <= 32'd0;
            rresp_r     <= RESP_OKAY;
            gie_r       <= 1'b0;
            ier_r       <= '0;
            isr_r       <= '0;
            interrupt_r <= 1'b0;
        end else if (ACLK_EN) begin
            if (aw_hs_s) begin
                waddr_r <= AWADDR;
            end
            if (w_hs_s) begin
                bresp_r <= ((wkind_s == KIND_NONE) || (wkind_s == KIND_INFO)) ? RESP_SLVERR : RESP_OKAY;
            end
            if (ar_hs_s) begin
                rdata_r <= rdata_s;
                rresp_r <= rresp_s;
            end
            gie_r       <= gie_s;
            ier_r       <= ier_s;
            isr_r       <= isr_s;
            interrupt_r <= gie_r && (|isr_r);
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        control_s_axi_mc_ch #(
            .NUM_ARGS   (NUM_ARGS),
            .CHAIN_MODE (CHAIN_MODE)
        ) u_ch (
            .ACLK        (ACLK),
            .ARESETN     (ARESETN),
            .ACLK_EN     (ACLK_EN),
            .ctrl_wr     (ctrl_wr_s[c]),
            .arg_wr      (arg_wr_s[c*NUM_ARGS +: NUM_ARGS]),
            .wdata       (WDATA),
            .wstrb       (WSTRB),
            .ctrl_rd     (ctrl_rd_s[c]),
            .gie         (gie_r),
            .ap_done     (ap_done[c]),
            .ap_ready    (ap_ready[c]),
            .ap_idle     (ap_idle[c]),
            .ctrl_rdata  (ctrl_rdata_s[c]),
            .ap_start    (ap_start[c]),
            .ap_continue (ap_continue[c]),
            .args        (ch_args_s[c*NUM_ARGS*32 +: NUM_ARGS*32])
        );
    end

    assign AWREADY   = (wstate_r == WRIDLE);
    assign WREADY    = (wstate_r == WRDATA);
    assign BVALID    = (wstate_r == WRRESP);
    assign BRESP     = bresp_r;
    assign ARREADY   = (rstate_r == RDIDLE);
    assign RVALID    = (rstate_r == RDDATA);
    assign RDATA     = rdata_r;
    assign RRESP     = rresp_r;
    assign interrupt = interrupt_r;
    assign ch_args   = ch_args_s;

endmodule

// File: tb/tb_control_s_axi_mc.sv
// Directed self-checking bench for control_s_axi_mc (4 channels, 3 args, chain mode on).
module tb_control_s_axi_mc;

    logic        ACLK = 1'b0;
    logic        ARESETN, ACLK_EN;
    logic [7:0]  AWADDR, ARADDR;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RVALID, RREADY;
    logic [31:0] WDATA, RDATA;
    logic [3:0]  WSTRB;
    logic [1:0]  BRESP, RRESP;
    logic        interrupt;
    logic [3:0]  ap_start, ap_continue, ap_done, ap_ready, ap_idle;
    logic [383:0] ch_args;

    int checks = 0;
    int failures = 0;

    logic [1:0]   bresp_v, rresp_v;
    logic [3:0]   cont1_v, cont2_v;
    logic         irq1_v, irq2_v;
    logic [31:0]  rdata_v;
    logic [383:0] exp_args;

    control_s_axi_mc #(
        .C_S_AXI_ADDR_WIDTH (8),
        .C_S_AXI_DATA_WIDTH (32),
        .NUM_CH             (4),
        .NUM_ARGS           (3),
        .CHAIN_MODE         (1)
    ) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .ACLK_EN(ACLK_EN),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .interrupt(interrupt), .ap_start(ap_start), .ap_continue(ap_continue),
        .ap_done(ap_done), .ap_ready(ap_ready), .ap_idle(ap_idle), .ch_args(ch_args)
    );

    always #5 ACLK = ~ACLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_high(input string name, ref logic sig);
        int n = 0;
        while (sig !== 1'b1 && n < 20) begin
            @(negedge ACLK);
            n++;
        end
        if (n >= 20) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: got %b required 1", name, sig);
        end
    endtask

    task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb);
        @(negedge ACLK);
        AWADDR = addr;
        AWVALID = 1'b1;
        wait_high("awready", AWREADY);
        @(negedge ACLK);
        AWVALID = 1'b0;
        WDATA = data;
        WSTRB = strb;
        WVALID = 1'b1;
        wait_high("wready", WREADY);
        @(negedge ACLK);
        WVALID = 1'b0;
        cont1_v = ap_continue;
        irq1_v = interrupt;
        BREADY = 1'b1;
        wait_high("bvalid", BVALID);
        bresp_v = BRESP;
        @(negedge ACLK);
        BREADY = 1'b0;
        cont2_v = ap_continue;
        irq2_v = interrupt;
    endtask

    task automatic axi_read(input logic [7:0] addr);
        @(negedge ACLK);
        ARADDR = addr;
        ARVALID = 1'b1;
        wait_high("arready", ARREADY);
        @(negedge ACLK);
        ARVALID = 1'b0;
        RREADY = 1'b1;
        wait_high("rvalid", RVALID);
        rdata_v = RDATA;
        rresp_v = RRESP;
        @(negedge ACLK);
        RREADY = 1'b0;
    endtask

    task automatic test_reset();
        ARESETN = 1'b0;
        AWVALID = 1'b1;
        AWADDR = 8'h00;
        for (int i = 0; i < 3; i++) begin
            @(posedge ACLK);
            @(negedge ACLK);
            checks++;
            if (AWREADY !== 1'b0) begin
                failures++;
                $display("FAIL reset_awready cycle %0d: got %b required 0", i, AWREADY);
            end
        end
        checks++;
        if ({ARREADY, WREADY, BVALID, RVALID, interrupt} !== 5'b00000) begin
            failures++;
            $display("FAIL reset_handshake: got %b required 00000", {ARREADY, WREADY, BVALID, RVALID, interrupt});
        end
        checks++;
        if ({ap_start, ap_continue} !== 8'h00) begin
            failures++;
            $display("FAIL reset_ap: got %h required 00", {ap_start, ap_continue});
        end
        checks++;
        if (ch_args !== 384'd0) begin
            failures++;
            $display("FAIL reset_args: got %h required 0", ch_args);
        end
        ARESETN = 1'b1;
        checks++;
        if ({AWREADY, ARREADY} !== 2'b00) begin
            failures++;
            $display("FAIL release_first_cycle: got %b required 00", {AWREADY, ARREADY});
        end
        @(negedge ACLK);
        checks++;
        if ({AWREADY, ARREADY} !== 2'b11) begin
            failures++;
            $display("FAIL release_second_cycle: got %b required 11", {AWREADY, ARREADY});
        end
        AWVALID = 1'b0;
    endtask

    task automatic test_info();
        axi_read(8'h0C);
        checks++;
        if (rdata_v !== 32'h0203_0401 || rresp_v !== 2'b00) begin
            failures++;
            $display("FAIL info_read: got %h/%b required 02030401/00", rdata_v, rresp_v);
        end
    endtask

    task automatic test_clock_enable();
        @(negedge ACLK);
        ACLK_EN = 1'b0;
        ARADDR = 8'h0C;
        ARVALID = 1'b1;
        repeat (3) @(negedge ACLK);
        checks++;
        if ({ARREADY, RVALID} !== 2'b10) begin
            failures++;
            $display("FAIL clock_enable_hold: got %b required 10", {ARREADY, RVALID});
        end
        ARVALID = 1'b0;
        ACLK_EN = 1'b1;
    endtask

    task automatic test_start_done();
        axi_write(8'h30, 32'h0000_0001, 4'hF);
        checks++;
        if (ap_start !== 4'b0100 || bresp_v !== 2'b00) begin
            failures++;
            $display("FAIL start_set: got %b/%b required 0100/00", ap_start, bresp_v);
        end
        ap_ready = 4'b0100;
        @(negedge ACLK);
        ap_ready = 4'b0000;
        checks++;
        if (ap_start !== 4'b0000) begin
            failures++;
            $display("FAIL start_clear_on_ready: got %b required 0000", ap_start);
        end
        ap_done = 4'b0100;
        @(negedge ACLK);
        ap_done = 4'b0000;
        axi_read(8'h30);
        checks++;
        if (rdata_v !== 32'h0000_000E) begin
            failures++;
            $display("FAIL ctrl_first_read: got %h required 0000000e", rdata_v);
        end
        axi_read(8'h30);
        checks++;
        if (rdata_v !== 32'h0000_0004) begin
            failures++;
            $display("FAIL ctrl_clear_on_read: got %h required 00000004", rdata_v);
        end
    endtask

    task automatic test_interrupt();
        axi_write(8'h00, 32'h0000_0001, 4'hF);
        axi_write(8'h04, 32'h0000_0004, 4'hF);
        axi_read(8'h30);
        checks++;
        if (rdata_v !== 32'h0000_0204) begin
            failures++;
            $display("FAIL ctrl_gie_bit: got %h required 00000204", rdata_v);
        end
        ap_done = 4'b0010;
        @(negedge ACLK);
        ap_done = 4'b0000;
        checks++;
        if (interrupt !== 1'b0) begin
            failures++;
            $display("FAIL irq_latency: got %b required 0", interrupt);
        end
        @(negedge ACLK);
        checks++;
        if (interrupt !== 1'b1) begin
            failures++;
            $display("FAIL irq_assert: got %b required 1", interrupt);
        end
        axi_read(8'h08);
        checks++;
        if (rdata_v !== 32'h0000_0004) begin
            failures++;
            $display("FAIL isr_read: got %h required 00000004", rdata_v);
        end
        axi_write(8'h08, 32'h0000_0004, 4'hF);
        checks++;
        if (irq1_v !== 1'b1 || irq2_v !== 1'b0) begin
            failures++;
            $display("FAIL irq_clear_timing: got %b%b required 10", irq1_v, irq2_v);
        end
        axi_read(8'h08);
        checks++;
        if (rdata_v !== 32'h0000_0000) begin
            failures++;
            $display("FAIL isr_toggle_clear: got %h required 00000000", rdata_v);
        end
    endtask

    task automatic test_args();
        axi_write(8'h14, 32'hDEAD_BEEF, 4'b0101);
        exp_args[31:0] = 32'h00AD_00EF;
        checks++;
        if (ch_args !== exp_args) begin
            failures++;
            $display("FAIL arg_strobe_write: got %h required %h", ch_args[31:0], exp_args[31:0]);
        end
        axi_read(8'h14);
        checks++;
        if (rdata_v !== 32'h00AD_00EF || rresp_v !== 2'b00) begin
            failures++;
            $display("FAIL arg_readback: got %h/%b required 00ad00ef/00", rdata_v, rresp_v);
        end
        axi_write(8'h48, 32'h1234_5678, 4'hF);
        axi_write(8'h48, 32'hAABB_CCDD, 4'b1000);
        exp_args[320 +: 32] = 32'hAA34_5678;
        checks++;
        if (ch_args !== exp_args) begin
            failures++;
            $display("FAIL arg_ch3_byte3: got %h required %h", ch_args[320 +: 32], exp_args[320 +: 32]);
        end
    endtask

    task automatic test_unmapped();
        axi_write(8'h0C, 32'hFFFF_FFFF, 4'hF);
        checks++;
        if (bresp_v !== 2'b10) begin
            failures++;
            $display("FAIL info_write_slverr: got %b required 10", bresp_v);
        end
        axi_write(8'h54, 32'hFFFF_FFFF, 4'hF);
        checks++;
        if (bresp_v !== 2'b10) begin
            failures++;
            $display("FAIL ch4_write_slverr: got %b required 10", bresp_v);
        end
        axi_read(8'h50);
        checks++;
        if (rdata_v !== 32'h0 || rresp_v !== 2'b10) begin
            failures++;
            $display("FAIL unmapped_read: got %h/%b required 00000000/10", rdata_v, rresp_v);
        end
        checks++;
        if (ch_args !== exp_args || ap_start !== 4'b0000) begin
            failures++;
            $display("FAIL unmapped_no_effect: got args %h start %b", ch_args, ap_start);
        end
        axi_read(8'h0C);
        checks++;
        if (rdata_v !== 32'h0203_0401) begin
            failures++;
            $display("FAIL info_unchanged: got %h required 02030401", rdata_v);
        end
    endtask

    task automatic test_auto_chain();
        axi_write(8'h40, 32'h0000_0081, 4'hF);
        checks++;
        if (ap_start !== 4'b1000) begin
            failures++;
            $display("FAIL auto_start_set: got %b required 1000", ap_start);
        end
        ap_ready = 4'b1000;
        @(negedge ACLK);
        ap_ready = 4'b0000;
        checks++;
        if (ap_start !== 4'b1000) begin
            failures++;
            $display("FAIL auto_restart_hold: got %b required 1000", ap_start);
        end
        axi_read(8'h40);
        checks++;
        if (rdata_v !== 32'h0000_0281) begin
            failures++;
            $display("FAIL auto_ctrl_read: got %h required 00000281", rdata_v);
        end
        axi_write(8'h10, 32'h0000_0010, 4'hF);
        checks++;
        if (cont1_v !== 4'b0001 || cont2_v !== 4'b0000) begin
            failures++;
            $display("FAIL continue_pulse: got %b then %b required 0001 then 0000", cont1_v, cont2_v);
        end
        checks++;
        if (ap_start !== 4'b1000) begin
            failures++;
            $display("FAIL continue_no_start: got %b required 1000", ap_start);
        end
    endtask

    initial begin
        ARESETN = 1'b0;
        ACLK_EN = 1'b1;
        AWADDR = 8'h00;
        AWVALID = 1'b0;
        WDATA = 32'h0;
        WSTRB = 4'h0;
        WVALID = 1'b0;
        BREADY = 1'b0;
        ARADDR = 8'h00;
        ARVALID = 1'b0;
        RREADY = 1'b0;
        ap_done = 4'b0000;
        ap_ready = 4'b0000;
        ap_idle = 4'b0101;
        exp_args = 384'd0;

        test_reset();
        test_info();
        test_clock_enable();
        test_start_done();
        test_interrupt();
        test_args();
        test_unmapped();
        test_auto_chain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
